// File: rtl/fb_pkg.sv
// Shared frame-buffer types and constants: 8-bit colour struct, 4x4 Bayer table,
// default geometry, and the colour helpers used by fb_pixel_format.
package fb_pkg;

   localparam int DEF_H_ACTIVE   = 1280;
   localparam int DEF_V_ACTIVE   = 720;
   localparam int DEF_BUS_BITS   = 128;
   localparam int DEF_PIXEL_BITS = 16;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } color8_t;

   // Row-major by {v[1:0], h[1:0]}
   localparam logic [3:0] BAYER_4X4 [16] = '{
      4'd0,  4'd8,  4'd2,  4'd10,
      4'd12, 4'd4,  4'd14, 4'd6,
      4'd3,  4'd11, 4'd1,  4'd9,
      4'd15, 4'd7,  4'd13, 4'd5
   };

   function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] d);
      logic [8:0] sum;
      sum = {1'b0, a} + {1'b0, d};
      return sum[8] ? 8'hFF : sum[7:0];
   endfunction

   // r/b get half the threshold, g a quarter, since g keeps one more bit after truncation
   function automatic color8_t dither_add(input color8_t c, input logic [3:0] bayer);
      color8_t o;
      o.r = sat_add8(c.r, {5'd0, bayer[3:1]});
      o.g = sat_add8(c.g, {6'd0, bayer[3:2]});
      o.b = sat_add8(c.b, {5'd0, bayer[3:1]});
      return o;
   endfunction

   function automatic logic [15:0] to_rgb565(input color8_t c);
      return {c.r[7:3], c.g[7:2], c.b[7:3]};
   endfunction

endpackage

// File: rtl/fb_pixel_format.sv
// Combinational colour conversion to RGB565 or xRGB8888.
// Ordered dither before RGB565 truncation when FB_PIXEL_PACKER_DITHER_EN is defined.
module fb_pixel_format
   import fb_pkg::*;
#(
   parameter int PIXEL_BITS = DEF_PIXEL_BITS
) (
   input  logic [23:0]           pixel_color,
   input  logic [1:0]            pos_h,
   input  logic [1:0]            pos_v,
   output logic [PIXEL_BITS-1:0] pixel_word
);

`ifdef FB_PIXEL_PACKER_DITHER_EN
   localparam bit DITHER = (PIXEL_BITS == 16);
`else
   localparam bit DITHER = 1'b0;
`endif

   color8_t    c_in;
   color8_t    c_dith;
   color8_t    c_sel;
   logic [3:0] bayer;

   assign c_in   = pixel_color;
   assign bayer  = BAYER_4X4[{pos_v, pos_h}];
   assign c_dith = dither_add(c_in, bayer);
   assign c_sel  = DITHER ? c_dith : c_in;

   generate
      if (PIXEL_BITS == 16) begin : g_rgb565
         assign pixel_word = to_rgb565(c_sel);
      end else begin : g_xrgb8888
         assign pixel_word = {8'h00, c_sel};
      end
   endgenerate

endmodule

// File: rtl/fb_pixel_packer.sv
// Packs raster-ordered pixels into BUS_BITS-wide AXI-Stream words with sequence checking.
// Optional ordered dither via FB_PIXEL_PACKER_DITHER_EN (handled in fb_pixel_format).
module fb_pixel_packer
   import fb_pkg::*;
#(
   parameter int PIXEL_BITS = DEF_PIXEL_BITS,
   parameter int BUS_BITS   = DEF_BUS_BITS,
   parameter int H_ACTIVE   = DEF_H_ACTIVE,
   parameter int V_ACTIVE   = DEF_V_ACTIVE
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                pixel_valid,
   output logic                pixel_ready,
   input  logic [23:0]         pixel_color,
   input  logic [10:0]         pixel_h,
   input  logic [9:0]          pixel_v,
   output logic                m_axis_tvalid,
   input  logic                m_axis_tready,
   output logic [BUS_BITS-1:0] m_axis_tdata,
   output logic                m_axis_tlast,
   output logic                m_axis_tuser,
   output logic                seq_err
);

   localparam int              PPW       = BUS_BITS / PIXEL_BITS;
   localparam int              LANE_W    = (PPW > 1) ? $clog2(PPW) : 1;
   localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(PPW - 1);
   localparam logic [10:0]     H_LAST    = 11'(H_ACTIVE - 1);
   localparam logic [9:0]      V_LAST    = 10'(V_ACTIVE - 1);

   logic [BUS_BITS-1:0]   acc_reg, acc_next;
   logic [LANE_W-1:0]     lane_reg, lane_next;
   logic                  user_reg, user_next;
   logic [10:0]           exp_h_reg, exp_h_next;
   logic [9:0]            exp_v_reg, exp_v_next;
   logic                  out_valid_reg, out_valid_next;
   logic [BUS_BITS-1:0]   out_data_reg, out_data_next;
   logic                  out_last_reg, out_last_next;
   logic                  out_user_reg, out_user_next;
   logic                  seq_err_reg, seq_err_next;

   logic [PIXEL_BITS-1:0] fmt_pixel;
   logic [LANE_W-1:0]     lane_idx;
   logic                  accept, at_origin, at_expected, in_seq, word_done, frame_end;

   fb_pixel_format #(
      .PIXEL_BITS (PIXEL_BITS)
   ) u_format (
      .pixel_color (pixel_color),
      .pos_h       (pixel_h[1:0]),
      .pos_v       (pixel_v[1:0]),
      .pixel_word  (fmt_pixel)
   );

   // Stall only when this pixel could finish a word that has nowhere to go
   assign pixel_ready = !((lane_reg == LANE_LAST) && out_valid_reg && !m_axis_tready);
   assign accept      = pixel_valid && pixel_ready;
   assign at_origin   = (pixel_h == 11'd0) && (pixel_v == 10'd0);
   assign at_expected = (pixel_h == exp_h_reg) && (pixel_v == exp_v_reg);
   assign in_seq      = accept && (at_origin || at_expected);
   assign lane_idx    = at_origin ? '0 : lane_reg;
   assign word_done   = in_seq && (lane_idx == LANE_LAST);
   assign frame_end   = (pixel_h == H_LAST) && (pixel_v == V_LAST);

   // A resync at (0,0) clears the stale partial word along with writing lane 0
   generate
      for (genvar gi = 0; gi < PPW; gi++) begin : g_lane
         assign acc_next[gi*PIXEL_BITS +: PIXEL_BITS] =
            (in_seq && (lane_idx == LANE_W'(gi))) ? fmt_pixel :
            (in_seq && at_origin)                 ? '0        :
                                                    acc_reg[gi*PIXEL_BITS +: PIXEL_BITS];
      end
   endgenerate

   always_comb begin
      lane_next      = lane_reg;
      user_next      = user_reg;
      exp_h_next     = exp_h_reg;
      exp_v_next     = exp_v_reg;
      out_valid_next = out_valid_reg;
      out_data_next  = out_data_reg;
      out_last_next  = out_last_reg;
      out_user_next  = out_user_reg;
      seq_err_next   = accept && !(at_origin || at_expected);

      if (out_valid_reg && m_axis_tready) begin
         out_valid_next = 1'b0;
      end

      if (in_seq) begin
         if (pixel_h == H_LAST) begin
            exp_h_next = 11'd0;
            exp_v_next = (pixel_v == V_LAST) ? 10'd0 : pixel_v + 10'd1;
         end else begin
            exp_h_next = pixel_h + 11'd1;
            exp_v_next = pixel_v;
         end

         if (word_done) begin
            out_valid_next = 1'b1;
            out_data_next  = acc_next;
            out_last_next  = frame_end;
            out_user_next  = at_origin || user_reg;
            lane_next      = '0;
            user_next      = 1'b0;
         end else begin
            lane_next      = lane_idx + LANE_W'(1);
            user_next      = at_origin || user_reg;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_reg       <= '0;
         lane_reg      <= '0;
         user_reg      <= 1'b0;
         exp_h_reg     <= 11'd0;
         exp_v_reg     <= 10'd0;
         out_valid_reg <= 1'b0;
         out_data_reg  <= '0;
         out_last_reg  <= 1'b0;
         out_user_reg  <= 1'b0;
         seq_err_reg   <= 1'b0;
      end else begin
         acc_reg       <= acc_next;
         lane_reg      <= lane_next;
         user_reg      <= user_next;
         exp_h_reg     <= exp_h_next;
         exp_v_reg     <= exp_v_next;
         out_valid_reg <= out_valid_next;
         out_data_reg  <= out_data_next;
         out_last_reg  <= out_last_next;
         out_user_reg  <= out_user_next;
         seq_err_reg   <= seq_err_next;
      end
   end

   assign m_axis_tvalid = out_valid_reg;
   assign m_axis_tdata  = out_data_reg;
   assign m_axis_tlast  = out_last_reg;
   assign m_axis_tuser  = out_user_reg;
   assign seq_err       = seq_err_reg;

endmodule

// File: tb/tb_fb_pixel_packer.sv
// Directed bench for fb_pixel_packer on a reduced 32x4 frame (RGB565, 128-bit words).
// Expected dither result follows FB_PIXEL_PACKER_DITHER_EN when the bench is built with it.
module tb_fb_pixel_packer;

   localparam int PB  = 16;
   localparam int BB  = 128;
   localparam int HA  = 32;
   localparam int VA  = 4;
   localparam int PPW = BB / PB;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          pixel_valid = 1'b0;
   logic          pixel_ready;
   logic [23:0]   pixel_color = '0;
   logic [10:0]   pixel_h = '0;
   logic [9:0]    pixel_v = '0;
   logic          m_axis_tvalid;
   logic          m_axis_tready = 1'b0;
   logic [BB-1:0] m_axis_tdata;
   logic          m_axis_tlast;
   logic          m_axis_tuser;
   logic          seq_err;

   int checks = 0;
   int passes = 0;
   int stall_cycles = 0;
   int seq_err_count = 0;

   logic [BB-1:0] q_data[$];
   logic          q_last[$];
   logic          q_user[$];

   always #5 clk = ~clk;

   fb_pixel_packer #(
      .PIXEL_BITS (PB),
      .BUS_BITS   (BB),
      .H_ACTIVE   (HA),
      .V_ACTIVE   (VA)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .pixel_valid   (pixel_valid),
      .pixel_ready   (pixel_ready),
      .pixel_color   (pixel_color),
      .pixel_h       (pixel_h),
      .pixel_v       (pixel_v),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tuser  (m_axis_tuser),
      .seq_err       (seq_err)
   );

   // Inputs only change at posedge+1, so negedge values are what the next edge transfers
   always @(negedge clk) begin
      if (!rst && m_axis_tvalid && m_axis_tready) begin
         q_data.push_back(m_axis_tdata);
         q_last.push_back(m_axis_tlast);
         q_user.push_back(m_axis_tuser);
         $display("word %0d: tdata=%h tuser=%0b tlast=%0b", q_data.size() - 1, m_axis_tdata, m_axis_tuser, m_axis_tlast);
      end
      if (!rst && seq_err) seq_err_count++;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [15:0] f16(input logic [23:0] c);
      return {c[23:19], c[15:10], c[7:3]};
   endfunction

   function automatic logic [23:0] ncol(input int n);
      logic [7:0] b;
      b = 8'(n * 8);
      return {b, b, b};
   endfunction

   function automatic logic [BB-1:0] word_of(input int base);
      logic [BB-1:0] w;
      w = '0;
      for (int k = 0; k < PPW; k++) w[k*PB +: PB] = f16(ncol(base + k));
      return w;
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      pixel_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      q_data.delete();
      q_last.delete();
      q_user.delete();
      seq_err_count = 0;
      stall_cycles = 0;
   endtask

   task automatic push(input int h, input int v, input logic [23:0] c);
      int n;
      n = 0;
      pixel_h = 11'(h);
      pixel_v = 10'(v);
      pixel_color = c;
      pixel_valid = 1'b1;
      while (!pixel_ready && n < 200) begin
         @(posedge clk);
         #1;
         n++;
         stall_cycles++;
      end
      if (!pixel_ready) begin
         checks++;
         $display("FAIL push_timeout: pixel (%0d,%0d) ready=%0b required 1", h, v, pixel_ready);
      end
      @(posedge clk);
      #1;
      $display("pixel (%0d,%0d) color=%h accepted", h, v, c);
      pixel_valid = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (m_axis_tvalid !== 1'b0) $display("FAIL rst_tvalid: got %0b required 0", m_axis_tvalid); else passes++;
      checks++; if (m_axis_tdata !== '0) $display("FAIL rst_tdata: got %h required 0", m_axis_tdata); else passes++;
      checks++; if (m_axis_tlast !== 1'b0) $display("FAIL rst_tlast: got %0b required 0", m_axis_tlast); else passes++;
      checks++; if (m_axis_tuser !== 1'b0) $display("FAIL rst_tuser: got %0b required 0", m_axis_tuser); else passes++;
      checks++; if (seq_err !== 1'b0) $display("FAIL rst_seq_err: got %0b required 0", seq_err); else passes++;
      checks++; if (pixel_ready !== 1'b1) $display("FAIL rst_ready: got %0b required 1", pixel_ready); else passes++;
   endtask

   task automatic test_frame();
      int data_bad, user_bad, last_bad, nwords;
      do_reset();
      m_axis_tready = 1'b1;
      for (int v = 0; v < VA; v++)
         for (int h = 0; h < HA; h++)
            push(h, v, 24'hF8FCF8);
      repeat (4) @(posedge clk);
      #1;
      nwords = HA * VA / PPW;
      data_bad = 0; user_bad = 0; last_bad = 0;
      for (int i = 0; i < q_data.size(); i++) begin
         if (q_data[i] !== {BB{1'b1}}) data_bad++;
         if (q_user[i] !== (i == 0)) user_bad++;
         if (q_last[i] !== (i == nwords - 1)) last_bad++;
      end
      checks++; if (q_data.size() != nwords) $display("FAIL frame_words: got %0d required %0d", q_data.size(), nwords); else passes++;
      checks++; if (data_bad != 0) $display("FAIL frame_tdata: %0d words not all-ones, required 0", data_bad); else passes++;
      checks++; if (user_bad != 0) $display("FAIL frame_tuser: %0d words wrong, required 0", user_bad); else passes++;
      checks++; if (last_bad != 0) $display("FAIL frame_tlast: %0d words wrong, required 0", last_bad); else passes++;
      checks++; if (stall_cycles != 0) $display("FAIL frame_stall: got %0d stall cycles required 0", stall_cycles); else passes++;
   endtask

   task automatic test_backpressure();
      logic [BB-1:0] w1, w2;
      w1 = word_of(0);
      w2 = word_of(8);
      do_reset();
      m_axis_tready = 1'b0;
      for (int n = 0; n < 7; n++) push(n, 0, ncol(n));
      checks++; if (m_axis_tvalid !== 1'b0) $display("FAIL bp_tvalid_early: got %0b required 0", m_axis_tvalid); else passes++;
      push(7, 0, ncol(7));
      checks++; if (m_axis_tvalid !== 1'b1) $display("FAIL bp_tvalid_rise: got %0b required 1", m_axis_tvalid); else passes++;
      checks++; if (m_axis_tdata !== w1) $display("FAIL bp_word1: got %h required %h", m_axis_tdata, w1); else passes++;
      for (int n = 8; n < 15; n++) push(n, 0, ncol(n));
      checks++; if (pixel_ready !== 1'b0) $display("FAIL bp_ready_low: got %0b required 0", pixel_ready); else passes++;
      pixel_h = 11'd15; pixel_v = 10'd0; pixel_color = ncol(15); pixel_valid = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (pixel_ready !== 1'b0) $display("FAIL bp_ready_hold: got %0b required 0", pixel_ready); else passes++;
      checks++; if (m_axis_tdata !== w1) $display("FAIL bp_word1_stable: got %h required %h", m_axis_tdata, w1); else passes++;
      m_axis_tready = 1'b1;
      #1;
      checks++; if (pixel_ready !== 1'b1) $display("FAIL bp_ready_release: got %0b required 1", pixel_ready); else passes++;
      @(posedge clk);
      #1;
      pixel_valid = 1'b0;
      checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== w2) $display("FAIL bp_word2_nobubble: tvalid=%0b tdata=%h required 1/%h", m_axis_tvalid, m_axis_tdata, w2); else passes++;
      checks++; if (q_data.size() != 1 || q_data[0] !== w1) $display("FAIL bp_word1_out: count=%0d required 1 word %h", q_data.size(), w1); else passes++;
      @(posedge clk);
      #1;
      checks++; if (m_axis_tvalid !== 1'b0) $display("FAIL bp_drain: got %0b required 0", m_axis_tvalid); else passes++;
      checks++; if (q_data.size() != 2 || q_data[1] !== w2) $display("FAIL bp_word2_out: count=%0d required 2 ending %h", q_data.size(), w2); else passes++;
   endtask

   task automatic test_seq_err();
      logic [BB-1:0] w1;
      w1 = word_of(0);
      do_reset();
      m_axis_tready = 1'b1;
      push(0, 0, ncol(0));
      push(1, 0, ncol(1));
      push(5, 0, 24'hFFFFFF);
      checks++; if (seq_err !== 1'b1) $display("FAIL seq_err_pulse: got %0b required 1", seq_err); else passes++;
      push(2, 0, ncol(2));
      checks++; if (seq_err !== 1'b0) $display("FAIL seq_err_one_cycle: got %0b required 0", seq_err); else passes++;
      for (int n = 3; n < 8; n++) push(n, 0, ncol(n));
      repeat (3) @(posedge clk);
      #1;
      checks++; if (seq_err_count != 1) $display("FAIL seq_err_count: got %0d required 1", seq_err_count); else passes++;
      checks++; if (q_data.size() != 1 || q_data[0] !== w1) $display("FAIL seq_word: count=%0d required 1 word %h", q_data.size(), w1); else passes++;
      checks++; if (q_data.size() < 1 || q_user[0] !== 1'b1) $display("FAIL seq_tuser: count=%0d required tuser 1", q_data.size()); else passes++;
   endtask

   task automatic test_resync();
      logic [BB-1:0] w1;
      logic [23:0]   xc;
      w1 = word_of(0);
      xc = 24'h102030;
      do_reset();
      m_axis_tready = 1'b0;
      for (int n = 0; n < 8; n++) push(n, 0, ncol(n));
      for (int n = 0; n < 3; n++) push(n, 0, ncol(n));
      push(0, 0, xc);
      for (int n = 1; n < 7; n++) push(n, 0, ncol(n));
      m_axis_tready = 1'b1;
      push(7, 0, ncol(7));
      repeat (3) @(posedge clk);
      #1;
      checks++; if (q_data.size() != 2) $display("FAIL resync_count: got %0d required 2", q_data.size()); else passes++;
      if (q_data.size() == 2) begin
         checks++; if (q_data[0] !== w1) $display("FAIL resync_pending_word: got %h required %h", q_data[0], w1); else passes++;
         checks++; if (q_data[1][PB-1:0] !== f16(xc)) $display("FAIL resync_lane0: got %h required %h", q_data[1][PB-1:0], f16(xc)); else passes++;
         checks++; if (q_data[1][BB-1:PB] !== w1[BB-1:PB]) $display("FAIL resync_lanes: got %h required %h", q_data[1][BB-1:PB], w1[BB-1:PB]); else passes++;
         checks++; if (q_user[1] !== 1'b1) $display("FAIL resync_tuser: got %0b required 1", q_user[1]); else passes++;
      end
   endtask

   task automatic test_reset_midword();
      logic [BB-1:0] w1;
      w1 = word_of(0);
      do_reset();
      m_axis_tready = 1'b0;
      for (int n = 0; n < 13; n++) push(n, 0, ncol(n + 20));
      rst = 1'b1;
      @(posedge clk);
      #1;
      checks++; if (m_axis_tvalid !== 1'b0) $display("FAIL midrst_tvalid: got %0b required 0", m_axis_tvalid); else passes++;
      checks++; if (pixel_ready !== 1'b1) $display("FAIL midrst_ready: got %0b required 1", pixel_ready); else passes++;
      checks++; if (m_axis_tdata !== '0) $display("FAIL midrst_tdata: got %h required 0", m_axis_tdata); else passes++;
      rst = 1'b0;
      m_axis_tready = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      checks++; if (q_data.size() != 0) $display("FAIL midrst_stale: got %0d words required 0", q_data.size()); else passes++;
      for (int n = 0; n < 8; n++) push(n, 0, ncol(n));
      repeat (3) @(posedge clk);
      #1;
      checks++; if (q_data.size() != 1 || q_data[0] !== w1) $display("FAIL midrst_fresh: count=%0d required 1 word %h", q_data.size(), w1); else passes++;
   endtask

   task automatic test_dither();
      logic [15:0] exp_px;
`ifdef FB_PIXEL_PACKER_DITHER_EN
      exp_px = 16'h083F;
`else
      exp_px = 16'h001F;
`endif
      do_reset();
      m_axis_tready = 1'b1;
      push(0, 0, 24'h000000);
      push(1, 0, 24'h0402FF);
      for (int n = 2; n < 8; n++) push(n, 0, 24'h000000);
      repeat (3) @(posedge clk);
      #1;
      checks++; if (q_data.size() != 1) $display("FAIL dither_count: got %0d required 1", q_data.size()); else passes++;
      if (q_data.size() == 1) begin
         checks++; if (q_data[0][2*PB-1:PB] !== exp_px) $display("FAIL dither_lane1: got %h required %h", q_data[0][2*PB-1:PB], exp_px); else passes++;
      end
   endtask

   initial begin
      test_reset();
      test_frame();
      test_backpressure();
      test_seq_err();
      test_resync();
      test_reset_midword();
      test_dither();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/fb_pixel_packer.md
FB_PIXEL_PACKER -- requirements
Module: fb_pixel_packer

Interface
REQ-001 SHALL have parameter PIXEL_BITS, default 16: 16 = RGB565, 32 = {8'h00,R,G,B}; other values are illegal.
REQ-002 SHALL have parameter BUS_BITS, default 128: output word width, a multiple of PIXEL_BITS; PPW = BUS_BITS/PIXEL_BITS.
REQ-003 SHALL have parameter H_ACTIVE, default 1280: pixels per line, a multiple of PPW.
REQ-004 SHALL have parameter V_ACTIVE, default 720: lines per frame.
REQ-005 SHALL have ports: clk in 1, system clock; rst in 1, synchronous active-high reset.
REQ-006 SHALL have ports: pixel_valid in 1; pixel_ready out 1; pixel_color in 24, {r,g,b} 8 bits each; pixel_h in 11; pixel_v in 10.
REQ-007 SHALL have ports: m_axis_tvalid out 1; m_axis_tready in 1; m_axis_tdata out BUS_BITS; m_axis_tlast out 1; m_axis_tuser out 1.
REQ-008 SHALL have port seq_err out 1: one-cycle pulse per dropped out-of-sequence pixel.

Function
REQ-009 A pixel transfer SHALL occur on any cycle where pixel_valid && pixel_ready are both high; an output transfer SHALL occur on any cycle where m_axis_tvalid && m_axis_tready are both high.
REQ-010 Format: 16-bit = {r[7:3],g[7:2],b[7:3]}; 32-bit = {8'h00,r,g,b}.
REQ-011 Packing: the k-th accepted pixel of a word SHALL occupy tdata[k*PIXEL_BITS +: PIXEL_BITS], with lane 0 in the LSBs.
REQ-012 Expected position (exp_h, exp_v) SHALL advance in raster order on each accepted in-sequence pixel; (H_ACTIVE-1, V_ACTIVE-1) SHALL wrap to (0,0).
REQ-013 A pixel at (0,0) SHALL always be accepted as in-sequence, discarding any partial word, setting lane=0, and setting exp=(1,0).
REQ-014 Any other pixel whose position differs from exp SHALL be accepted (consumed), not packed, and SHALL pulse seq_err for one cycle; lane and exp SHALL NOT change.
REQ-015 When lane PPW-1 is filled, the complete word SHALL move to the output register; m_axis_tvalid SHALL rise the cycle after that pixel is accepted.
REQ-016 m_axis_tuser SHALL be 1 on the word containing pixel (0,0); m_axis_tlast SHALL be 1 on the word containing (H_ACTIVE-1, V_ACTIVE-1).
REQ-017 tdata, tlast and tuser SHALL be held stable while tvalid && !tready.
REQ-018 pixel_ready SHALL be low only when the accumulator is one lane from full and the output register is occupied and not being accepted that cycle; with tready held high, throughput SHALL be one pixel per cycle.
REQ-019 When the output register drains and a new word completes on the same cycle, the new word SHALL load with no bubble.
REQ-020 A (0,0) resync SHALL NOT affect a word already in the output register.

Reset
REQ-021 On rst: m_axis_tvalid=0, tdata=0, tlast=0, tuser=0, seq_err=0, pixel_ready=1, lane=0, exp=(0,0).
REQ-022 Reset asserted mid-word or with an output word pending SHALL discard all held data, with no partial word emitted.

Configuration
REQ-023 With FB_PIXEL_PACKER_DITHER_EN defined and PIXEL_BITS=16, before truncation r and b SHALL add B>>1, and g SHALL add B>>2, saturating at 255. B is the 4x4 Bayer value (0..15) indexed by {pixel_v[1:0], pixel_h[1:0]}.
REQ-024 Without FB_PIXEL_PACKER_DITHER_EN, or when PIXEL_BITS=32, the format SHALL be pure truncation per REQ-010; latency SHALL be identical in both builds.

Structure
REQ-025 A shared package fb_pkg SHALL hold the color8 struct, the Bayer 4x4 table, and the default H_ACTIVE/V_ACTIVE/BUS_BITS constants.
REQ-026 Format conversion, including dither, SHALL be a combinational sub-module fb_pixel_format; packing, sequencing and the output register SHALL live in fb_pixel_packer.

Verification
REQ-027 Stream a full 1280x720 frame of r=8'hF8,g=8'hFC,b=8'hF8 with tready=1 (defaults) -> 115200 words, each tdata=128'hFFFF...FFFF; tuser on word 0 only, tlast on word 115199 only; no stall.
REQ-028 Pixels (0,0)..(7,0) with colors n=0..7 as {n,n,n}<<3, tready=0 -> tvalid=1 one cycle after the 8th pixel; tdata stable; pixel_ready=0 after 7 further pixels; tready=1 releases the word unchanged.
REQ-029 Send (0,0),(1,0), then (5,0) -> seq_err pulses once and (5,0) is not packed; then (2,0)..(7,0) -> one word with lanes 0..7 = pixels 0..7.
REQ-030 Send 3 pixels, then (0,0) -> no word emitted; the next word has tuser=1 and lane 0 = the new (0,0) pixel.
REQ-031 Assert rst after 5 pixels with a word pending -> next cycle tvalid=0, pixel_ready=1; no stale word appears afterwards.
REQ-032 With FB_PIXEL_PACKER_DITHER_EN, color {8'h04,8'h02,8'hFF} at h=1,v=0 (B=8) -> r=8'h08→5'h01, g=8'h04→6'h01, b saturates→5'h1F; without the macro -> 16'h001F.
